// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MIPS32 MEM stage.
//   - register-file widths and NOP constants
//   - EXE_*_OP operation codes used by the MEM stage
//   - MEM_* state encodings of the bus-transaction FSM
//   - decode_op(): classifies an operation code into access size/kind
package mem_access_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      sext;
    mem_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [7:0] aluop);
    mem_op_t op;
    op = '{is_mem: 1'b0, is_load: 1'b0, sext: 1'b0, size: SZ_NONE};
    case (aluop)
      EXE_LB_OP:  op = '{1'b1, 1'b1, 1'b1, SZ_BYTE};
      EXE_LBU_OP: op = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
      EXE_LH_OP:  op = '{1'b1, 1'b1, 1'b1, SZ_HALF};
      EXE_LHU_OP: op = '{1'b1, 1'b1, 1'b0, SZ_HALF};
      EXE_LW_OP:  op = '{1'b1, 1'b1, 1'b0, SZ_WORD};
      EXE_SB_OP:  op = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
      EXE_SH_OP:  op = '{1'b1, 1'b0, 1'b0, SZ_HALF};
      EXE_SW_OP:  op = '{1'b1, 1'b0, 1'b0, SZ_WORD};
      default:    ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// mem_lane: combinational byte-lane logic shared by the request path (live
// EX/MEM inputs) and the response path (latched operation + bus read data).
// Optional feature macro: MEM_ALIGN_CHECK_EN (reports misalignment instead of
// silently forcing alignment).
// Ports:
//   aluop_i    operation code
//   off_i      raw address offset (addr[1:0])
//   reg2_i     store source data
//   rdata_i    bus read data
//   is_mem_o   operation is a load or store
//   is_load_o  operation is a load
//   misalign_o misaligned access (always 0 unless MEM_ALIGN_CHECK_EN)
//   off_o      offset forced to the natural alignment of the access size
//   sel_o      byte-lane select, bit 3 = bits [31:24] (big-endian)
//   wdata_o    store data replicated across lanes
//   ldata_o    selected load lane, sign/zero extended
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic        is_mem_o,
  output logic        is_load_o,
  output logic        misalign_o,
  output logic [1:0]  off_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  mem_op_t     op;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    op         = decode_op(aluop_i);
    is_mem_o   = op.is_mem;
    is_load_o  = op.is_load;
    misalign_o = 1'b0;
    off_o      = off_i;
    sel_o      = 4'b0000;
    wdata_o    = '0;
    ldata_o    = '0;
    byte_v     = '0;
    half_v     = '0;
    case (op.size)
      SZ_BYTE: begin
        sel_o   = 4'b1000 >> off_i;
        wdata_o = {4{reg2_i[7:0]}};
        case (off_i)
          2'b00:   byte_v = rdata_i[31:24];
          2'b01:   byte_v = rdata_i[23:16];
          2'b10:   byte_v = rdata_i[15:8];
          default: byte_v = rdata_i[7:0];
        endcase
        ldata_o = {{24{op.sext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
`ifdef MEM_ALIGN_CHECK_EN
        misalign_o = off_i[0];
`endif
        off_o   = {off_i[1], 1'b0};
        sel_o   = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{reg2_i[15:0]}};
        half_v  = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        ldata_o = {{16{op.sext & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
`ifdef MEM_ALIGN_CHECK_EN
        misalign_o = |off_i;
`endif
        off_o   = 2'b00;
        sel_o   = 4'b1111;
        wdata_o = reg2_i;
        ldata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MIPS32 MEM stage. Non-memory results pass straight through to
// MEM/WB; loads/stores run as IDLE -> REQ -> DONE transactions on a req/ack
// bus while stallreq holds the pipeline.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned half/word accesses
// skip the bus and finish with bus_err; otherwise low address bits are forced
// to alignment.
// Parameter: BUS_TIMEOUT -- REQ cycles waited for bus_ack before an error.
// Ports:
//   clk, rst (async, active-low)
//   mem_wd/mem_wreg/mem_wdata/mem_aluop/mem_addr/mem_reg2  from EX/MEM
//   wb_wd/wb_wreg/wb_wdata                                 to MEM/WB
//   stallreq                                               pipeline hold
//   bus_req/bus_we/bus_addr/bus_sel/bus_wdata              bus request
//   bus_ack/bus_rdata                                      bus response
//   bus_err                                                one-cycle error pulse
module mem_access
  import mem_access_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [7:0]            mem_aluop,
  input  logic [31:0]           mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [31:0]           bus_addr,
  output logic [3:0]            bus_sel,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  mem_state_e            state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic [RegAddrBus-1:0] rd_q, rd_d;
  logic [29:0]           addr_q, addr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [RegBus-1:0]     result_q, result_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // The lane logic sees the live inputs while IDLE (request side) and the
  // latched operation afterwards, so the response path never re-samples EX/MEM.
  logic        idle;
  logic [7:0]  lane_aluop;
  logic [1:0]  lane_off;
  logic        lane_is_mem, lane_is_load, lane_misalign;
  logic [1:0]  lane_off_al;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_ldata;

  assign idle       = (state_q == MEM_IDLE);
  assign lane_aluop = idle ? mem_aluop : op_q;
  assign lane_off   = idle ? mem_addr[1:0] : off_q;

  mem_lane u_lane (
    .aluop_i    (lane_aluop),
    .off_i      (lane_off),
    .reg2_i     (mem_reg2),
    .rdata_i    (bus_rdata),
    .is_mem_o   (lane_is_mem),
    .is_load_o  (lane_is_load),
    .misalign_o (lane_misalign),
    .off_o      (lane_off_al),
    .sel_o      (lane_sel),
    .wdata_o    (lane_wdata),
    .ldata_o    (lane_ldata)
  );

  // Bus fields come only from latches, so they cannot move while bus_req=1.
  assign bus_req   = (state_q == MEM_REQ);
  assign bus_addr  = {addr_q, 2'b00};
  assign bus_sel   = sel_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    wb_wd    = NOPRegAddr;
    wb_wreg  = 1'b0;
    wb_wdata = ZeroWord;
    stallreq = 1'b0;
    bus_err  = 1'b0;

    case (state_q)
      MEM_IDLE: begin
        if (lane_is_mem) begin
          stallreq = 1'b1;
          op_d     = mem_aluop;
          off_d    = lane_off_al;
          rd_d     = mem_wd;
          addr_d   = mem_addr[31:2];
          sel_d    = lane_sel;
          wdata_d  = lane_wdata;
          we_d     = ~lane_is_load;
          result_d = ZeroWord;
          err_d    = lane_misalign;
          cnt_d    = '0;
          state_d  = lane_misalign ? MEM_DONE : MEM_REQ;
        end else begin
          wb_wd    = mem_wd;
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end
      end
      MEM_REQ: begin
        stallreq = 1'b1;
        // An ack in the final allowed cycle still completes the access.
        if (bus_ack) begin
          result_d = lane_is_load ? lane_ldata : ZeroWord;
          state_d  = MEM_DONE;
        end else if (cnt_q == CNT_W'(BUS_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = MEM_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_DONE: begin
        wb_wd    = rd_q;
        wb_wdata = result_q;
        wb_wreg  = lane_is_load & ~err_q;
        bus_err  = err_q;
        state_d  = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase

    // While reset is held the passthrough path must not leak EX/MEM values.
    if (!rst) begin
      wb_wd    = NOPRegAddr;
      wb_wreg  = 1'b0;
      wb_wdata = ZeroWord;
      stallreq = 1'b0;
      bus_err  = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register updates from
  // the same pre-edge values regardless of statement order.
  // NOTE: the transaction latches are reset too, so an access abandoned by
  // reset leaves nothing stale on the bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MEM_IDLE;
      op_q     <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the MIPS32 pipeline, between the EX/MEM and MEM/WB pipeline registers. It passes non-memory results straight through. It runs LB/LBU/LH/LHU/LW/SB/SH/SW as multi-cycle transactions on a req/ack data bus, and holds the pipeline with `stallreq` until the access completes. Load data is extracted per byte lane (big-endian) and extended before being forwarded to MEM/WB.

## Interface
- `BUS_TIMEOUT`, default 255: maximum REQ cycles waited for `bus_ack` before a bus error is flagged.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous reset, active-low; asserted when 0.
- `mem_wd` in 5: destination register, from EX/MEM.
- `mem_wreg` in 1: write enable, from EX/MEM.
- `mem_wdata` in 32: ALU result, from EX/MEM.
- `mem_aluop` in 8: operation code; `EXE_*_OP` load/store codes.
- `mem_addr` in 32: effective address.
- `mem_reg2` in 32: store source data.
- `wb_wd` out 5: destination register, to MEM/WB.
- `wb_wreg` out 1: write enable, to MEM/WB.
- `wb_wdata` out 32: result, to MEM/WB.
- `stallreq` out 1: stall request to the pipeline controller.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: 1 = store.
- `bus_addr` out 32: word-aligned address; bits [1:0] = 0.
- `bus_sel` out 4: byte-lane select; bit 3 = bits [31:24].
- `bus_wdata` out 32: store data, replicated across lanes.
- `bus_ack` in 1: transaction complete; `bus_rdata` is valid in this cycle.
- `bus_rdata` in 32: read data.
- `bus_err` out 1: one-cycle pulse on timeout (and misalignment when configured).

## Operation
- States:
  - **IDLE**: non-memory op → `wb_*` = `mem_*` combinationally, `stallreq`=0. Memory op → `stallreq`=1, next state REQ; latch op, address, select and data.
  - **REQ**: `bus_req`=1 (registered), `stallreq`=1, timeout counter increments. `bus_ack`=1 → latch the extended load result, next state DONE. Counter reaches `BUS_TIMEOUT` → set error flag, next state DONE.
  - **DONE**: `stallreq`=0; `wb_wd`=latched rd, `wb_wdata`=latched result. `wb_wreg`=1 only for a load with no error; stores and errors give 0. `bus_err` equals the error flag. Next state IDLE unconditionally.
- Lane mapping by `mem_addr[1:0]`:
  - Byte: 00→1000, 01→0100, 10→0010, 11→0001.
  - Half: 00→1100, 10→0011.
  - Word: 1111.
- Load extension:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend.
  - LW takes all 32 bits.
- Store data:
  - SB: `{4{reg2[7:0]}}`.
  - SH: `{2{reg2[15:0]}}`.
  - SW: `reg2`.
- `bus_addr`, `bus_we`, `bus_sel` and `bus_wdata` are stable for the whole time `bus_req`=1.
- `bus_ack` outside REQ is ignored.
- Reset values (any state, including mid-transaction): state IDLE, `bus_req`=0, counter=0, latches=0, `wb_wd`=0, `wb_wreg`=0, `wb_wdata`=0, `stallreq`=0, `bus_err`=0. An outstanding bus transaction is abandoned.

## Timing
- Non-memory op: 0-cycle latency, no stall.
- Memory op:
  - Arrives in cycle 0, with `stallreq`=1.
  - `bus_req` is high from cycle 1.
  - If ack is sampled in cycle k, DONE is cycle k+1, and the pipeline advances at the end of k+1.
  - Zero-wait-state access: 3 cycles in MEM, 2 of them stalled.
- `bus_req` falls in the cycle after ack. A new request needs at least one IDLE cycle in between.
- Timeout: with no ack, DONE is reached after `BUS_TIMEOUT` REQ cycles.
- The upstream register holds its inputs while `stallreq`=1. The block does not re-sample them in REQ or DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned access (half with `addr[0]`=1, word with `addr[1:0]`≠0) skips REQ and goes IDLE→DONE.
  - No bus transaction is issued; `bus_err`=1 and `wb_wreg`=0 in DONE.
- Undefined:
  - Low address bits are forced to alignment (half: `addr[0]`=0; word: `addr[1:0]`=0).
  - The access proceeds normally.

## Structure
- The `EXE_LB_OP` … `EXE_SW_OP` codes, `RegAddrBus`/`RegBus` widths and `NOPRegAddr`/`ZeroWord` belong in the shared define file. The state encodings also go there, with a `MEM_` prefix.
- One sub-module, `mem_lane`: combinational lane select, extension and store replication, shared by the request and response paths.

## Test plan
- ADDU passthrough, rd=3, wdata=0x1234 → same cycle `wb_wd`=3, `wb_wreg`=1, `wb_wdata`=0x1234, `stallreq`=0.
- LB at addr 0x1001, ack in the first REQ cycle, rdata=0x11F2_3344 → `bus_sel`=0100, `bus_addr`=0x1000; DONE `wb_wdata`=0xFFFFFFF2; 2 stall cycles.
- SH at addr 0x2002, reg2=0xAAAA_BEEF, ack after 3 wait cycles → `bus_we`=1, `bus_sel`=0011, `bus_wdata`=0xBEEFBEEF held stable; DONE `wb_wreg`=0.
- LW with no ack, `BUS_TIMEOUT`=4 → `bus_req` high for 4 cycles; DONE `bus_err`=1, `wb_wreg`=0; back to IDLE.
- LW at 0x3002:
  - With `MEM_ALIGN_CHECK_EN`: no `bus_req`, `bus_err`=1.
  - Without it: `bus_addr`=0x3000, `bus_sel`=1111.
- `rst`=0 asserted during REQ → immediately `bus_req`=0, `stallreq`=0, all `wb_*`=0; after release, the next instruction starts from IDLE.
